spi_master_arbiter: RTL
=======================

Name: spi_master_arbiter

Overview:
- Shares one `spi_master` transaction engine between NUM_REQ independent requesters.
- Grants requesters round-robin, one at a time.
- Issues one start pulse per grant, waits for the engine's completion, then returns the received word to the granted requester.
- Enforces an idle gap between transactions so the chip select (`cs_b`) deasserts for a minimum time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, SPI word width in bits
GAP_CYCLES, 2, idle clocks enforced after each transaction (0 allowed)
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  request per requester, level, held until done
req_data  in  NUM_REQ*DATA_W  tx word; requester i uses [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot grant, held from START through end of WAIT
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rx_data  out  DATA_W  received word; valid in the done cycle, held until the next done
busy  out  1  high in every state except IDLE
m_start  out  1  one-cycle start pulse to the SPI master
m_tx_data  out  DATA_W  word to transmit; stable from m_start until m_done
m_done  in  1  one-cycle completion pulse from the SPI master
m_rx_data  in  DATA_W  received word from the SPI master, valid with m_done
timeout_err  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
Reset:
- State returns to IDLE.
- gnt, done, rx_data, busy, m_start, m_tx_data, timeout_err all return to 0.
- Round-robin pointer ptr returns to 0.

State machine (IDLE, START, WAIT, GAP):
- IDLE:
  - If req != 0, select the first set req bit searching upward from ptr, wrapping modulo NUM_REQ.
  - Register idx and m_tx_data <= req_data slice idx; go to START.
  - If req == 0, stay in IDLE.
- START (exactly 1 cycle):
  - m_start=1 and gnt[idx]=1; go to WAIT.
- WAIT:
  - gnt[idx] held.
  - On m_done:
    - rx_data <= m_rx_data
    - done[idx] pulses in the next cycle
    - ptr <= (idx+1) mod NUM_REQ
    - gnt cleared in the next cycle
    - go to GAP, or straight to IDLE if GAP_CYCLES==0
- GAP:
  - Counter runs from 0 to GAP_CYCLES-1, then go to IDLE. No arbitration in GAP.

Latency:
- Request seen in IDLE at cycle N gives m_start and gnt at cycle N+1.
- m_done at cycle M gives done and rx_data valid at cycle M+1.
- Minimum spacing between two m_start pulses is (SPI duration + 2 + GAP_CYCLES) cycles.

Boundary rules:
- A req deasserted while granted is ignored; the transaction completes and done still pulses.
- req_data changes after capture are ignored.
- m_done outside WAIT is ignored, as is m_done coincident with m_start.
- Only the requester at ptr wins on simultaneous requests. The losers stay pending and win later in round-robin order, so there is no starvation.
- A single requester holding req continuously is served back-to-back, separated by GAP.
- Reset mid-transaction aborts immediately; no done is issued. The SPI master shares rst.
- idx and ptr widths are clog2(NUM_REQ); wrap uses an explicit modulo for non-power-of-2 NUM_REQ.

Optional Feature:
SPI_ARB_TIMEOUT_EN:
- When defined, a watchdog counter is cleared on entry to WAIT and increments every WAIT cycle.
- If the counter reaches TIMEOUT_CYCLES without m_done:
  - timeout_err pulses 1 cycle.
  - done[idx] pulses with rx_data forced to all-ones.
  - ptr advances and the state goes to GAP.
- When undefined, there is no counter, timeout_err is tied 0, and WAIT waits indefinitely.

Test Plan:
1. Single requester: req=4'b0010, req_data slice1=8'hA5, m_done 16 cycles after m_start with m_rx_data=8'h3C -> m_start one cycle after req, m_tx_data=8'hA5, gnt=4'b0010, done=4'b0010 one cycle after m_done, rx_data=8'h3C.
2. Round-robin: req=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0. Each pair of m_start pulses is spaced by SPI duration+2+GAP_CYCLES.
3. Requester drops req during WAIT -> transaction completes, done pulses, the next arbitration skips it.
4. Spurious m_done in IDLE and in GAP -> no done pulse, no state change, rx_data unchanged.
5. rst asserted in WAIT -> all outputs 0 asynchronously, ptr=0. After release with req=4'b0100, requester 2 is granted.
6. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=32, m_done never driven -> timeout_err and done[idx] pulse 32 cycles after WAIT entry, rx_data=8'hFF, next requester served.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master engine among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts a stalled transaction in WAIT.
module spi_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      m_start,
    output logic [DATA_W-1:0]         m_tx_data,
    input  logic                      m_done,
    input  logic [DATA_W-1:0]         m_rx_data,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state
);
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    // Handshake: req is a level held by the requester until its one-cycle done
    // pulse; the engine side is a one-cycle m_start answered by a one-cycle m_done.

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  idx_next;
    logic              sel_found;
    logic [GAP_W-1:0]  gap_cnt;
    logic              wd_expire;
    logic              xfer_end;
    logic [DATA_W-1:0] end_data;
    logic [DATA_W-1:0] req_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign req_words[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First requester at or above ptr, wrapping; explicit modulo keeps non-power-of-2 counts in range.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign idx_next  = IDX_W'((int'(idx) + 1) % NUM_REQ);
    assign xfer_end  = (state == ST_WAIT) && (m_done || wd_expire);
    assign end_data  = m_done ? m_rx_data : '1;
    assign m_start   = (state == ST_START);
    assign gnt       = ((state == ST_START) || (state == ST_WAIT)) ? (ONE_HOT0 << idx) : '0;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == ST_START) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_expire && !m_done) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            ptr       <= '0;
            m_tx_data <= '0;
            rx_data   <= '0;
            done      <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        idx       <= sel_idx;
                        m_tx_data <= req_words[sel_idx];
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (xfer_end) begin
                        rx_data <= end_data;
                        done    <= ONE_HOT0 << idx;
                        ptr     <= idx_next;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
